adder_result_checker: RTL and testbench
=======================================

# adder_result_checker

Sequential launch/capture stage wrapped around the 32-bit combinational fast adder. It accepts operand triples over a valid/ready handshake and holds them in launch registers that drive the adder. After a parameterised settle interval it samples the adder's sum and carry-out and compares them against a behavioural reference. It then presents the captured result with a pass/fail flag, and keeps transaction and error counts for delay characterisation runs.

## Interface
- N, 32, operand/sum width; matches the adder under test
- SETTLE, 2, clock edges from launch to capture; legal range 1..15
- CNT_W, 16, width of the transaction and error counters
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  operand triple valid
- in_ready  out  1  stage can accept; high only in IDLE
- in_a, in_b  in  N  operands
- in_cin  in  1  carry-in
- add_a, add_b  out  N  launch registers; drive the adder A/B inputs
- add_cin  out  1  launch register; drives the adder Cin
- add_sum  in  N  adder sum output
- add_cout  in  1  adder carry-out
- out_valid  out  1  captured result valid
- out_ready  in  1  downstream accepts the result
- out_sum  out  N  captured sum
- out_cout  out  1  captured carry-out
- out_err  out  1  captured {cout,sum} differs from the reference
- cnt_clr  in  1  synchronous clear of both counters
- txn_count  out  CNT_W  number of captures; saturating
- err_count  out  CNT_W  number of mismatching captures; saturating

## Operation
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge, load add_a/add_b/add_cin from in_a/in_b/in_cin, load the settle counter with SETTLE-1, and go to WAIT.
- WAIT:
  - in_ready=0, and the launch registers are stable.
  - The counter decrements each edge.
  - At the edge where the counter is 0, capture out_sum=add_sum and out_cout=add_cout.
  - At the same edge, set out_err = ({add_cout,add_sum} != {1'b0,add_a}+{1'b0,add_b}+add_cin), computed at N+1 bits, then go to HOLD.
- HOLD:
  - out_valid=1, and the out_* outputs are stable.
  - On out_ready at an edge, go to IDLE.
  - The launch registers keep their values until the next accept.
- Counters:
  - At the capture edge, txn_count increments by 1, and err_count increments by 1 if the mismatch is set.
  - Both counters saturate at 2^CNT_W-1 (no wrap).
  - cnt_clr zeroes both counters at the next edge and takes priority over a simultaneous increment.
  - cnt_clr does not affect the FSM.
- Only one transaction is in flight; there is no buffering.
- in_valid outside IDLE is ignored. Upstream must hold its data until in_ready is high.

## Timing
- Reset values (rst_n=0 at an edge):
  - State IDLE.
  - in_ready=1 after reset.
  - out_valid=0, out_sum=0, out_cout=0, out_err=0.
  - add_a=0, add_b=0, add_cin=0.
  - Both counters 0, settle counter 0.
- Reset mid-transaction: any in-flight or held result is discarded and the counters are not updated.
- Accept at edge t0: add_* are valid after t0.
- Capture at edge t0+SETTLE: out_valid is high in the cycle after t0+SETTLE.
- Fastest round trip: with out_ready tied high, the handshake completes at t0+SETTLE+1 and in_ready is high after it. The next accept is at t0+SETTLE+2, giving an initiation interval of SETTLE+2.
- SETTLE=1: WAIT lasts one cycle, and capture happens at the first edge after the launch edge.
- out_valid, once high, stays high with stable data until the accepting edge.
- The path from the launch registers through the adder to the capture registers is a SETTLE-cycle multicycle path. Synthesis constraints must set it to SETTLE.

## Test plan
- Reset then a single transaction:
  - Stimulus: a=0x0000_0001, b=0xFFFF_FFFF, cin=0, SETTLE=2, correct adder.
  - Required: out_sum=0, out_cout=1, out_err=0; out_valid rises 2 edges after accept; txn_count=1, err_count=0.
- Full carry ripple:
  - Stimulus: a=0xFFFF_FFFF, b=0, cin=1.
  - Required: out_sum=0, out_cout=1, out_err=0.
- Fault injection:
  - Stimulus: force add_sum bit 22 to 0 with a=0x003F_FFFF, b=1, cin=0.
  - Required: out_err=1, out_sum=0x0000_0000, err_count increments.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid, and drive in_valid during HOLD.
  - Required: out_* stable, in_ready=0, no second accept. The handshake occurs at the first edge with out_ready=1, and in_ready=1 on the next cycle.
- Reset mid-WAIT:
  - Stimulus: assert rst_n=0 at edge t0+1 with SETTLE=4.
  - Required: out_valid=0, add_*=0, counters unchanged at 0, in_ready=1.
- Counter saturation and clear:
  - Stimulus: CNT_W=2, 5 back-to-back transactions, then cnt_clr coincident with a capture edge.
  - Required: txn_count stops at 3; after the clear edge both counters are 0.

Source files
------------

// File: rtl/adder_result_checker.sv
// Launch/capture harness around a combinational N-bit adder: launches operands,
// waits SETTLE edges, samples the adder output and scores it against a reference.
module adder_result_checker #(
   parameter int N      = 32,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   input  logic             in_cin,
   output logic [N-1:0]     add_a,
   output logic [N-1:0]     add_b,
   output logic             add_cin,
   input  logic [N-1:0]     add_sum,
   input  logic             add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_sum,
   output logic             out_cout,
   output logic             out_err,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] txn_count,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [N-1:0]     add_a_q, add_a_d, add_b_q, add_b_d;
   logic             add_cin_q, add_cin_d;
   logic [N-1:0]     out_sum_q, out_sum_d;
   logic             out_cout_q, out_cout_d;
   logic             out_err_q, out_err_d;
   logic [CNT_W-1:0] txn_q, txn_d, err_q, err_d;
   logic [N:0]       ref_sum;
   logic             mismatch;
   logic             capture;

   // Launch-register-to-capture path is a SETTLE-cycle multicycle path; constrain it so.
   assign ref_sum  = {1'b0, add_a_q} + {1'b0, add_b_q} + {{N{1'b0}}, add_cin_q};
   assign mismatch = ({add_cout, add_sum} != ref_sum);
   assign capture  = (state_q == WAIT) && (cnt_q == 4'd0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      add_a_d    = add_a_q;
      add_b_d    = add_b_q;
      add_cin_d  = add_cin_q;
      out_sum_d  = out_sum_q;
      out_cout_d = out_cout_q;
      out_err_d  = out_err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               add_a_d   = in_a;
               add_b_d   = in_b;
               add_cin_d = in_cin;
               cnt_d     = SETTLE_M1;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (capture) begin
               out_sum_d  = add_sum;
               out_cout_d = add_cout;
               out_err_d  = mismatch;
               state_d    = HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Clear wins over a coincident increment; both counters saturate at all-ones.
   always_comb begin
      txn_d = txn_q;
      err_d = err_q;
      if (cnt_clr) begin
         txn_d = '0;
         err_d = '0;
      end else if (capture) begin
         if (txn_q != '1)             txn_d = txn_q + 1'b1;
         if (mismatch && err_q != '1) err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         add_a_q    <= '0;
         add_b_q    <= '0;
         add_cin_q  <= 1'b0;
         out_sum_q  <= '0;
         out_cout_q <= 1'b0;
         out_err_q  <= 1'b0;
         txn_q      <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         add_a_q    <= add_a_d;
         add_b_q    <= add_b_d;
         add_cin_q  <= add_cin_d;
         out_sum_q  <= out_sum_d;
         out_cout_q <= out_cout_d;
         out_err_q  <= out_err_d;
         txn_q      <= txn_d;
         err_q      <= err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == HOLD);
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign add_cin   = add_cin_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
   assign out_err   = out_err_q;
   assign txn_count = txn_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench: instance A (SETTLE=2, CNT_W=16) and instance B (SETTLE=4, CNT_W=2),
// each driving a behavioural adder with a forceable fault mask on its sum.
module tb_adder_result_checker;

   localparam int N = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [N-1:0] in_a = '0, in_b = '0;
   logic         in_cin = 1'b0;
   logic         out_ready = 1'b1;

   // instance A
   logic         rst_a = 1'b0, in_valid_a = 1'b0, in_ready_a;
   logic [N-1:0] add_a_a, add_b_a, add_sum_a, out_sum_a, ref_a, fault_a = '0;
   logic         add_cin_a, add_cout_a, out_valid_a, out_cout_a, out_err_a;
   logic [15:0]  txn_a, err_a;
   assign {add_cout_a, ref_a} = {1'b0, add_a_a} + {1'b0, add_b_a} + {{N{1'b0}}, add_cin_a};
   assign add_sum_a = ref_a & ~fault_a;

   adder_result_checker #(.N(N), .SETTLE(2), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .add_a(add_a_a), .add_b(add_b_a), .add_cin(add_cin_a),
      .add_sum(add_sum_a), .add_cout(add_cout_a),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .out_sum(out_sum_a), .out_cout(out_cout_a), .out_err(out_err_a),
      .cnt_clr(1'b0), .txn_count(txn_a), .err_count(err_a));

   // instance B
   logic         rst_b = 1'b0, in_valid_b = 1'b0, in_ready_b, cnt_clr_b = 1'b0;
   logic [N-1:0] add_a_b, add_b_b, add_sum_b, out_sum_b, ref_b, fault_b = '0;
   logic         add_cin_b, add_cout_b, out_valid_b, out_cout_b, out_err_b;
   logic [1:0]   txn_b, err_b;
   assign {add_cout_b, ref_b} = {1'b0, add_a_b} + {1'b0, add_b_b} + {{N{1'b0}}, add_cin_b};
   assign add_sum_b = ref_b & ~fault_b;

   adder_result_checker #(.N(N), .SETTLE(4), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .add_a(add_a_b), .add_b(add_b_b), .add_cin(add_cin_b),
      .add_sum(add_sum_b), .add_cout(add_cout_b),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .out_sum(out_sum_b), .out_cout(out_cout_b), .out_err(out_err_b),
      .cnt_clr(cnt_clr_b), .txn_count(txn_b), .err_count(err_b));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset both instances
      step(); step();
      chk("rst_in_ready",  64'(in_ready_a),  64'd1);
      chk("rst_out_valid", 64'(out_valid_a), 64'd0);
      chk("rst_out_sum",   64'(out_sum_a),   64'd0);
      chk("rst_out_cout",  64'(out_cout_a),  64'd0);
      chk("rst_out_err",   64'(out_err_a),   64'd0);
      chk("rst_add_a",     64'(add_a_a),     64'd0);
      chk("rst_add_cin",   64'(add_cin_a),   64'd0);
      chk("rst_txn",       64'(txn_a),       64'd0);
      chk("rst_err",       64'(err_a),       64'd0);
      rst_a = 1'b1;
      rst_b = 1'b1;

      // single transaction, round trip with out_ready high
      in_a = 32'h0000_0001; in_b = 32'hFFFF_FFFF; in_cin = 1'b0; in_valid_a = 1'b1;
      step();                                   // accept edge t0
      in_valid_a = 1'b0;
      chk("t1_in_ready_wait", 64'(in_ready_a), 64'd0);
      chk("t1_add_b",         64'(add_b_a),    64'hFFFF_FFFF);
      step();                                   // t0+1
      chk("t1_valid_early",   64'(out_valid_a), 64'd0);
      step();                                   // t0+2 capture
      chk("t1_valid",  64'(out_valid_a), 64'd1);
      chk("t1_sum",    64'(out_sum_a),   64'd0);
      chk("t1_cout",   64'(out_cout_a),  64'd1);
      chk("t1_err",    64'(out_err_a),   64'd0);
      chk("t1_txn",    64'(txn_a),       64'd1);
      chk("t1_errcnt", 64'(err_a),       64'd0);
      step();                                   // t0+3 handshake
      chk("t1_valid_drop", 64'(out_valid_a), 64'd0);
      chk("t1_ready_back", 64'(in_ready_a),  64'd1);

      // full carry ripple
      in_a = 32'hFFFF_FFFF; in_b = 32'h0; in_cin = 1'b1; in_valid_a = 1'b1;
      step(); in_valid_a = 1'b0;
      step(); step();
      chk("t2_valid", 64'(out_valid_a), 64'd1);
      chk("t2_sum",   64'(out_sum_a),   64'd0);
      chk("t2_cout",  64'(out_cout_a),  64'd1);
      chk("t2_err",   64'(out_err_a),   64'd0);
      chk("t2_txn",   64'(txn_a),       64'd2);
      step();

      // stuck-at-0 on sum bit 22
      fault_a = 32'h0040_0000;
      in_a = 32'h003F_FFFF; in_b = 32'h1; in_cin = 1'b0; in_valid_a = 1'b1;
      step(); in_valid_a = 1'b0;
      step(); step();
      chk("t3_err",    64'(out_err_a),  64'd1);
      chk("t3_sum",    64'(out_sum_a),  64'd0);
      chk("t3_cout",   64'(out_cout_a), 64'd0);
      chk("t3_errcnt", 64'(err_a),      64'd1);
      chk("t3_txn",    64'(txn_a),      64'd3);
      step();
      fault_a = '0;

      // backpressure with a competing in_valid during HOLD
      out_ready = 1'b0;
      in_a = 32'h5; in_b = 32'h7; in_cin = 1'b1; in_valid_a = 1'b1;
      step(); in_valid_a = 1'b0;
      step(); step();
      chk("t4_valid", 64'(out_valid_a), 64'd1);
      in_a = 32'h100; in_b = 32'h200; in_valid_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_hold_valid", 64'(out_valid_a), 64'd1);
         chk("t4_hold_sum",   64'(out_sum_a),   64'hD);
         chk("t4_hold_ready", 64'(in_ready_a),  64'd0);
         chk("t4_hold_add_a", 64'(add_a_a),     64'h5);
      end
      in_valid_a = 1'b0;
      out_ready = 1'b1;
      step();
      chk("t4_release_valid", 64'(out_valid_a), 64'd0);
      chk("t4_release_ready", 64'(in_ready_a),  64'd1);
      chk("t4_txn",           64'(txn_a),       64'd4);
      chk("t4_add_a_kept",    64'(add_a_a),     64'h5);

      // reset in the middle of WAIT (SETTLE=4)
      in_a = 32'h1; in_b = 32'h2; in_cin = 1'b0; in_valid_b = 1'b1;
      step();                                   // accept t0
      in_valid_b = 1'b0;
      chk("t5_launch", 64'(add_a_b), 64'h1);
      rst_b = 1'b0;
      step();                                   // t0+1 reset
      rst_b = 1'b1;
      chk("t5_valid", 64'(out_valid_b), 64'd0);
      chk("t5_add_a", 64'(add_a_b),     64'd0);
      chk("t5_add_b", 64'(add_b_b),     64'd0);
      chk("t5_ready", 64'(in_ready_b),  64'd1);
      chk("t5_txn",   64'(txn_b),       64'd0);
      repeat (5) step();
      chk("t5_no_capture", 64'(out_valid_b), 64'd0);
      chk("t5_txn_after",  64'(txn_b),       64'd0);

      // saturation with faulty adder: both counters stop at 3
      fault_b = '1;
      for (int i = 0; i < 5; i++) begin
         in_valid_b = 1'b1;
         step();
         in_valid_b = 1'b0;
         repeat (4) step();
         chk("t6_valid",  64'(out_valid_b), 64'd1);
         chk("t6_err",    64'(out_err_b),   64'd1);
         chk("t6_txn",    64'(txn_b),       64'((i < 3) ? i + 1 : 3));
         chk("t6_errcnt", 64'(err_b),       64'((i < 3) ? i + 1 : 3));
         step();
      end
      in_valid_b = 1'b1;
      step();
      in_valid_b = 1'b0;
      repeat (3) step();
      cnt_clr_b = 1'b1;
      step();                                   // capture and clear share this edge
      cnt_clr_b = 1'b0;
      chk("t7_valid",  64'(out_valid_b), 64'd1);
      chk("t7_txn",    64'(txn_b),       64'd0);
      chk("t7_errcnt", 64'(err_b),       64'd0);
      step();
      chk("t7_ready",  64'(in_ready_b),  64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
